en_param: RTL
=============

# en_param

Parametrised stochastic equality node of degree D with a circular edge memory (EM). It sits between the channel-probability stochastic stream and the parity-check nodes (PCN) of the stochastic decoder, one instance per variable-node edge. Its timing is fully synchronous: the output is registered, the EM is loaded from the channel bit during an INIT phase, and a consecutive-hold stall detector is included.

## Interface
- D, 6: node degree; the number of PCN inputs is D-1 (must be ≥2).
- EM_S, 8: EM depth in bits; power of 2, ≥2.
- AW, 3: EM address width; must equal log2(EM_S).
- STALL_TH, 16: consecutive hold cycles that assert STALL; range 1..255.
- D_EN, 1: simulation-only delay on Q; it has no effect in synthesis.

- CLK_D2S  in  1  decoder clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- INIT  in  1  level; high = EM load phase.
- c  in  1  channel probability stochastic bit.
- R  in  D-1  stochastic bits from the PCNs.
- EM_SEL  in  AW  EM read address from the LFSR.
- Q  out  1  registered output bit to the PCNs.
- U  out  1  registered regeneration flag; 1 = the previous cycle was non-hold.
- READY  out  1  the EM has been fully loaded since the last INIT rise.
- STALL  out  1  the hold run has reached STALL_TH.

## Operation
- Combinational terms, evaluated over the vector {R, c}:
  - agree1 = AND of all bits; agree0 = NOR of all bits.
  - nh = agree1 | agree0 (non-hold).
- FSM states are IDLE, FILL and RUN. Reset enters IDLE.
- IDLE:
  - Q=0; no EM writes.
  - INIT=1 → FILL.
- FILL, entered on any cycle with INIT=1 from any state:
  - The INIT rising edge (INIT=1 while in IDLE or RUN) clears wp and fcnt in that same cycle and writes c to EM[0].
  - Each cycle: EM[wp] <= c; wp <= wp+1 (mod EM_S); Q <= c.
  - fcnt saturates at EM_S. READY <= (fcnt reaches EM_S).
  - INIT=0 → RUN.
- RUN:
  - If nh=1: Q <= c; EM[wp] <= c; wp <= wp+1 mod EM_S; U <= 1.
  - Otherwise: Q <= EM[EM_SEL]; U <= 0.
  - The read uses pre-write contents, so a same-cycle write never bypasses to Q.
- The EM is never written during hold cycles.
- If RUN is entered with READY=0 (short INIT), unwritten entries keep their reset value 0. Operation still proceeds and READY stays 0.
- Stall counter hcnt (8-bit):
  - Cleared on reset, in FILL, and on any nh=1 cycle in RUN.
  - Incremented on hold cycles in RUN, saturating at 255.
  - STALL = (hcnt ≥ STALL_TH), registered.
- U is 0 in IDLE and 1 in FILL.

## Timing
- Reset (RST_N=0, asynchronous):
  - Q=0, U=0, READY=0, STALL=0.
  - EM all 0, wp=0, fcnt=0, hcnt=0, state IDLE.
  - Release is synchronous to the next CLK_D2S edge.
- Latency: inputs sampled at edge n appear on Q after edge n (1 cycle). The behavioural model additionally delays Q by D_EN.
- READY timing:
  - Rises on the edge that completes the EM_S-th FILL write, i.e. EM_S cycles after the INIT rise.
  - Stays high until reset or the next INIT rise, when it falls on that same edge.
- STALL rises on the edge where hcnt becomes STALL_TH and falls on the first nh=1 edge.
- wp wraps EM_S-1 → 0 with no pause.
- Reset mid-FILL or mid-RUN aborts immediately; all state returns to reset values.
- INIT reasserted in RUN restarts FILL from wp=0.
- All R bits are treated identically; input ordering is irrelevant.

## Test plan
- Reset, then INIT high 8 cycles with D=6, EM_S=8, c=1,0,1,1,0,0,1,0, then INIT=0:
  - READY rises on the 8th edge.
  - EM = 1,0,1,1,0,0,1,0 at addresses 0..7.
  - Q follows c with 1-cycle delay.
- After that fill, RUN with R=5'b10101, c=1 (hold) and EM_SEL stepping 0..7: Q = 1,0,1,1,0,0,1,0, U=0, EM unchanged.
- RUN with R=5'b11111, c=1 for 3 cycles:
  - Q=1, U=1.
  - EM[0..2] overwritten to 1 and wp=3.
  - Then R=5'b00000, c=0 writes 0 at EM[3].
- Hold for 16 consecutive cycles with STALL_TH=16: STALL rises on the 16th edge. The next all-agree cycle clears it on that edge.
- INIT pulsed for 3 cycles only (c=1), then hold with EM_SEL=5: READY stays 0 and Q=0 (unwritten entry).
- Assert RST_N=0 mid-RUN, asynchronously between edges: Q, U, READY and STALL go to 0 immediately. The next INIT refills from wp=0.

Source files
------------

// File: rtl/en_param.sv
// Stochastic equality node of degree D with a circular edge memory (EM),
// registered output, INIT-phase EM load and a consecutive-hold stall detector.
module en_param #(
  parameter int D        = 6,
  parameter int EM_S     = 8,
  parameter int AW       = 3,
  parameter int STALL_TH = 16,
  parameter int D_EN     = 1
) (
  input  logic          CLK_D2S,
  input  logic          RST_N,
  input  logic          INIT,
  input  logic          c,
  input  logic [D-2:0]  R,
  input  logic [AW-1:0] EM_SEL,
  output logic          Q,
  output logic          U,
  output logic          READY,
  output logic          STALL
);

  localparam logic [AW:0] FULL = (AW+1)'(EM_S);
  localparam logic [7:0]  TH   = 8'(STALL_TH);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t          state, state_nx;
  logic [EM_S-1:0] em, em_nx;
  logic [AW-1:0]   wp, wp_nx, wr_addr;
  logic [AW:0]     fcnt, fcnt_nx, cnt_base;
  logic [7:0]      hcnt, hcnt_nx;
  logic            q_nx, u_nx, ready_nx, stall_nx;
  logic [D-1:0]    vec;
  logic            nh;

  // D_EN only shapes the behavioural output delay; the synthesised Q is undelayed.
  logic unused_den;
  assign unused_den = (D_EN != 0);

  assign vec = {R, c};
  assign nh  = (&vec) | ~(|vec);

  always_comb begin
    state_nx = state;
    em_nx    = em;
    wp_nx    = wp;
    fcnt_nx  = fcnt;
    hcnt_nx  = hcnt;
    q_nx     = Q;
    u_nx     = U;
    ready_nx = READY;
    wr_addr  = '0;
    cnt_base = '0;

    if (INIT) begin
      // Any INIT cycle outside FILL is a rising edge: restart from EM[0].
      state_nx = FILL;
      wr_addr  = (state == FILL) ? wp : '0;
      cnt_base = (state == FILL) ? fcnt : '0;
      em_nx[wr_addr] = c;
      wp_nx    = wr_addr + 1'b1;
      fcnt_nx  = (cnt_base == FULL) ? cnt_base : cnt_base + 1'b1;
      ready_nx = (fcnt_nx == FULL);
      q_nx     = c;
      u_nx     = 1'b1;
      hcnt_nx  = '0;
    end else if (state != IDLE) begin
      state_nx = RUN;
      if (nh) begin
        em_nx[wp] = c;
        wp_nx     = wp + 1'b1;
        q_nx      = c;
        u_nx      = 1'b1;
        hcnt_nx   = '0;
      end else begin
        q_nx = em[EM_SEL];
        u_nx = 1'b0;
        if (hcnt != 8'hFF) hcnt_nx = hcnt + 1'b1;
      end
    end else begin
      q_nx = 1'b0;
      u_nx = 1'b0;
    end

    stall_nx = (hcnt_nx >= TH);
  end

  always_ff @(posedge CLK_D2S or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      em    <= '0;
      wp    <= '0;
      fcnt  <= '0;
      hcnt  <= '0;
      Q     <= 1'b0;
      U     <= 1'b0;
      READY <= 1'b0;
      STALL <= 1'b0;
    end else begin
      state <= state_nx;
      em    <= em_nx;
      wp    <= wp_nx;
      fcnt  <= fcnt_nx;
      hcnt  <= hcnt_nx;
      Q     <= q_nx;
      U     <= u_nx;
      READY <= ready_nx;
      STALL <= stall_nx;
    end
  end

endmodule
